dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline load/store port and the L2 word interface.
- Serves BYTE/HALF/WORD loads and stores. Hits complete combinationally in the request cycle.
- Misses write back a dirty victim line if needed, then fill the line one 32-bit word at a time from L2.

---
 rtl/dcache.sv | 210 +++++++++++++++++++++
 tb/tb_dcache.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a word-serial L2 port.
// Define DCACHE_PERF_COUNTERS_EN to add the hit_count / miss_count outputs.
package dcache_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_SIZE  = 16,
  parameter int unsigned CACHE_SIZE = 256,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       pipe_req_address,
  input  memory_operation_size_e pipe_req_size,
  input  memory_operation_e     pipe_req_type,
  input  logic                  pipe_req_valid,
  input  logic [XLEN-1:0]       pipe_word_to_store,
  output logic [XLEN-1:0]       pipe_fetched_word,
  output logic                  pipe_fetched_word_valid,
  output logic [XLEN-1:0]       l2_req_address,
  output memory_operation_e     l2_req_type,
  output logic                  l2_req_valid,
  output logic [XLEN-1:0]       l2_word_to_store,
  input  logic [XLEN-1:0]       l2_fetched_word,
  input  logic                  l2_fetched_word_valid
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_SIZE);
  localparam int unsigned NUM_LINES   = CACHE_SIZE / LINE_SIZE;
  localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS    = XLEN - OFFSET_BITS - INDEX_BITS;
  localparam int unsigned WORDS       = LINE_SIZE / 4;
  localparam int unsigned WSEL_BITS   = OFFSET_BITS - 2;
  localparam int unsigned LANES       = XLEN / 8;
  localparam logic [WSEL_BITS-1:0] LAST_WORD = WSEL_BITS'(WORDS - 1);

  typedef enum logic [1:0] {StCompare, StWriteback, StAllocate} state_e;

  state_e                  state_q, state_d;
  logic [WSEL_BITS-1:0]    ctr_q, ctr_d;
  logic [TAG_BITS-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0]   miss_index_q, miss_index_d;
  logic [NUM_LINES-1:0]    valid_q, dirty_q;
  logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
  logic [XLEN-1:0]         data_q [NUM_LINES][WORDS];

  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   req_index;
  logic [WSEL_BITS-1:0]    req_wsel;
  logic [1:0]              req_boff, boff_eff;
  logic [LANES-1:0]        be;
  logic [XLEN-1:0]         wdata, bitmask, line_word, shifted, load_word, merged_word;
  logic                    hit, hit_store, miss_start, wb_done, fill_we, fill_done;

  assign req_tag   = pipe_req_address[XLEN-1 -: TAG_BITS];
  assign req_index = pipe_req_address[OFFSET_BITS +: INDEX_BITS];
  assign req_wsel  = pipe_req_address[2 +: WSEL_BITS];
  assign req_boff  = pipe_req_address[1:0];
  assign line_word = data_q[req_index][req_wsel];
  assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);

  // Size decode: byte enables, lane-replicated store data and effective byte offset.
  always_comb begin
    be       = '1;
    wdata    = pipe_word_to_store;
    boff_eff = 2'b00;
    unique case (pipe_req_size)
      BYTE: begin
        be       = LANES'(1) << req_boff;
        wdata    = {LANES{pipe_word_to_store[7:0]}};
        boff_eff = req_boff;
      end
      HALF: begin
        be       = LANES'(2'b11) << {req_boff[1], 1'b0};
        wdata    = {(LANES / 2){pipe_word_to_store[15:0]}};
        boff_eff = {req_boff[1], 1'b0};
      end
      default: ;
    endcase
    for (int i = 0; i < LANES; i++) begin
      bitmask[8*i +: 8] = {8{be[i]}};
    end
    shifted     = line_word >> {boff_eff, 3'b000};
    merged_word = (line_word & ~bitmask) | (wdata & bitmask);
    unique case (pipe_req_size)
      BYTE:    load_word = {{(XLEN-8){1'b0}}, shifted[7:0]};
      HALF:    load_word = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_word = line_word;
    endcase
  end

  always_comb begin
    state_d                 = state_q;
    ctr_d                   = ctr_q;
    miss_tag_d              = miss_tag_q;
    miss_index_d            = miss_index_q;
    pipe_fetched_word       = '0;
    pipe_fetched_word_valid = 1'b0;
    l2_req_address          = '0;
    l2_req_type             = LOAD;
    l2_req_valid            = 1'b0;
    l2_word_to_store        = '0;
    hit_store               = 1'b0;
    miss_start              = 1'b0;
    wb_done                 = 1'b0;
    fill_we                 = 1'b0;
    fill_done               = 1'b0;
    unique case (state_q)
      StCompare: begin
        if (pipe_req_valid) begin
          if (hit) begin
            pipe_fetched_word_valid = 1'b1;
            if (pipe_req_type == LOAD) pipe_fetched_word = load_word;
            else                       hit_store = 1'b1;
          end else begin
            miss_start   = 1'b1;
            miss_tag_d   = req_tag;
            miss_index_d = req_index;
            ctr_d        = '0;
            state_d      = (valid_q[req_index] && dirty_q[req_index]) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        l2_req_valid     = 1'b1;
        l2_req_type      = STORE;
        l2_req_address   = {tag_q[miss_index_q], miss_index_q, ctr_q, 2'b00};
        l2_word_to_store = data_q[miss_index_q][ctr_q];
        ctr_d            = ctr_q + 1'b1;
        if (ctr_q == LAST_WORD) begin
          wb_done = 1'b1;
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        l2_req_valid   = 1'b1;
        l2_req_address = {miss_tag_q, miss_index_q, ctr_q, 2'b00};
        if (l2_fetched_word_valid) begin
          fill_we = 1'b1;
          ctr_d   = ctr_q + 1'b1;
          if (ctr_q == LAST_WORD) begin
            fill_done = 1'b1;
            state_d   = StCompare;
          end
        end
      end
      default: state_d = StCompare;
    endcase
    if (reset) begin
      pipe_fetched_word       = '0;
      pipe_fetched_word_valid = 1'b0;
      l2_req_valid            = 1'b0;
      l2_req_type             = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StCompare;
      ctr_q        <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      if (hit_store) dirty_q[req_index] <= 1'b1;
      // The victim stays readable for writeback; it just stops hitting.
      if (miss_start) valid_q[req_index] <= 1'b0;
      if (wb_done) dirty_q[miss_index_q] <= 1'b0;
      if (fill_done) begin
        valid_q[miss_index_q] <= 1'b1;
        dirty_q[miss_index_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (hit_store) data_q[req_index][req_wsel] <= merged_word;
      if (fill_we)   data_q[miss_index_q][ctr_q] <= l2_fetched_word;
      if (fill_done) tag_q[miss_index_q]         <= miss_tag_q;
    end
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (pipe_fetched_word_valid && pipe_req_valid) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed and random-load bench for dcache with a combinational word-serial L2 model.
module tb_dcache;
  import dcache_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [31:0]            pipe_req_address;
  memory_operation_size_e pipe_req_size;
  memory_operation_e      pipe_req_type;
  logic                   pipe_req_valid;
  logic [31:0]            pipe_word_to_store;
  logic [31:0]            pipe_fetched_word;
  logic                   pipe_fetched_word_valid;
  logic [31:0]            l2_req_address;
  memory_operation_e      l2_req_type;
  logic                   l2_req_valid;
  logic [31:0]            l2_word_to_store;
  logic [31:0]            l2_fetched_word;
  logic                   l2_fetched_word_valid;
`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0]            hit_count, miss_count;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        stall_en = 1'b0;
  logic        l2_ready = 1'b1;
  logic [31:0] l2_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ld_log[$];
  logic [31:0] st_addr[$];
  logic [31:0] st_data[$];

  dcache dut (
    .clk                     (clk),
    .reset                   (reset),
    .pipe_req_address        (pipe_req_address),
    .pipe_req_size           (pipe_req_size),
    .pipe_req_type           (pipe_req_type),
    .pipe_req_valid          (pipe_req_valid),
    .pipe_word_to_store      (pipe_word_to_store),
    .pipe_fetched_word       (pipe_fetched_word),
    .pipe_fetched_word_valid (pipe_fetched_word_valid),
    .l2_req_address          (l2_req_address),
    .l2_req_type             (l2_req_type),
    .l2_req_valid            (l2_req_valid),
    .l2_word_to_store        (l2_word_to_store),
    .l2_fetched_word         (l2_fetched_word),
    .l2_fetched_word_valid   (l2_fetched_word_valid)
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    .hit_count               (hit_count),
    .miss_count              (miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] l2_word(input logic [31:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input memory_operation_size_e s);
    logic [31:0] w;
    w = ref_mem.exists({a[31:2], 2'b00}) ? ref_mem[{a[31:2], 2'b00}] : dflt({a[31:2], 2'b00});
    case (s)
      BYTE:    return {24'h0, w[8*a[1:0] +: 8]};
      HALF:    return {16'h0, (a[1] ? w[31:16] : w[15:0])};
      default: return w;
    endcase
  endfunction

  // Combinational L2: fill data valid in the same cycle as the request unless stalled.
  always @(l2_req_address or l2_req_valid or l2_req_type or l2_ready) begin
    l2_fetched_word       = l2_word(l2_req_address);
    l2_fetched_word_valid = l2_req_valid && (l2_req_type == LOAD) && l2_ready;
  end

  always @(posedge clk) begin
    #2;
    l2_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset && l2_req_valid) begin
      if (l2_req_type == STORE) begin
        st_addr.push_back(l2_req_address);
        st_data.push_back(l2_word_to_store);
        l2_mem[l2_req_address] = l2_word_to_store;
      end else if (l2_fetched_word_valid) begin
        ld_log.push_back(l2_req_address);
      end
    end
  end

  task automatic clear_logs();
    ld_log.delete();
    st_addr.delete();
    st_data.delete();
  endtask

  // Called at a falling edge; returns at a falling edge with the request dropped.
  task automatic do_req(input logic [31:0] a, input memory_operation_size_e s,
                        input memory_operation_e t, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    pipe_req_address   = a;
    pipe_req_size      = s;
    pipe_req_type      = t;
    pipe_word_to_store = wd;
    pipe_req_valid     = 1'b1;
    cyc = 0;
    #1;
    while (pipe_fetched_word_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    rd = pipe_fetched_word;
    vectors++;
    if (pipe_fetched_word_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ack: addr %h no ack after %0d cycles, required ack", a, cyc);
    end
    @(negedge clk);
    pipe_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pipe_req_address = 32'h1008;
    pipe_req_size    = WORD;
    pipe_req_type    = LOAD;
    pipe_req_valid   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (pipe_fetched_word_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_pvalid: got %b want 0", pipe_fetched_word_valid);
    end
    vectors++;
    if (pipe_fetched_word !== 32'h0) begin
      miscompares++; $display("FAIL reset_pword: got %h want 0", pipe_fetched_word);
    end
    vectors++;
    if (l2_req_valid !== 1'b0 || l2_req_type !== LOAD) begin
      miscompares++;
      $display("FAIL reset_l2: got valid %b type %0d want valid 0 type LOAD", l2_req_valid,
               l2_req_type);
    end
    pipe_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (l2_req_valid !== 1'b0 || pipe_fetched_word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_outputs: got l2 %b pipe %b want 0 0", l2_req_valid,
               pipe_fetched_word_valid);
    end
`ifdef DCACHE_PERF_COUNTERS_EN
    vectors++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_cold_load();
    logic [31:0] rd;
    int cyc;
    clear_logs();
    do_req(32'h1008, WORD, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h1234_5678) begin
      miscompares++; $display("FAIL cold_data: got %h want 12345678", rd);
    end
    vectors++;
    if (cyc != 5) begin
      miscompares++; $display("FAIL cold_latency: got %0d want 5", cyc);
    end
    vectors++;
    if (ld_log.size() != 4 || st_addr.size() != 0) begin
      miscompares++;
      $display("FAIL cold_traffic: got %0d loads %0d stores want 4 0", ld_log.size(),
               st_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (ld_log[i] !== 32'h1000 + 32'(4 * i)) begin
          miscompares++; $display("FAIL cold_addr%0d: got %h want %h", i, ld_log[i], 32'h1000 + 4 * i);
        end
      end
    end
  endtask

  task automatic test_hit();
    logic [31:0] rd;
    int cyc;
    clear_logs();
    do_req(32'h100B, BYTE, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h12 || cyc != 0) begin
      miscompares++; $display("FAIL hit_byte: got %h in %0d cycles want 00000012 in 0", rd, cyc);
    end
    do_req(32'h100A, HALF, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h1234 || cyc != 0) begin
      miscompares++; $display("FAIL hit_half: got %h in %0d cycles want 00001234 in 0", rd, cyc);
    end
    do_req(32'h1009, HALF, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h5678) begin
      miscompares++; $display("FAIL hit_half_unaligned: got %h want 00005678", rd);
    end
    vectors++;
    if (ld_log.size() != 0 || st_addr.size() != 0) begin
      miscompares++; $display("FAIL hit_traffic: got %0d/%0d want 0/0", ld_log.size(), st_addr.size());
    end
  endtask

  task automatic test_store();
    logic [31:0] rd;
    int cyc;
    clear_logs();
    do_req(32'h1002, HALF, STORE, 32'hFFFF_BEEF, rd, cyc);
    vectors++;
    if (rd !== 32'h0 || cyc != 0) begin
      miscompares++; $display("FAIL store_ack: got %h in %0d cycles want 0 in 0", rd, cyc);
    end
    ref_mem[32'h1000] = 32'hBEEF_AAAA;
    do_req(32'h1000, WORD, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'hBEEF_AAAA) begin
      miscompares++; $display("FAIL store_half: got %h want beefaaaa", rd);
    end
    do_req(32'h1005, BYTE, STORE, 32'h0000_005C, rd, cyc);
    ref_mem[32'h1004] = 32'h1122_5C44;
    do_req(32'h1004, WORD, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h1122_5C44) begin
      miscompares++; $display("FAIL store_byte: got %h want 11225c44", rd);
    end
    do_req(32'h100F, WORD, STORE, 32'h0102_0304, rd, cyc);
    ref_mem[32'h100C] = 32'h0102_0304;
    do_req(32'h100C, WORD, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h0102_0304) begin
      miscompares++; $display("FAIL store_word: got %h want 01020304", rd);
    end
    // Hold a byte store for three cycles; it must be acknowledged every cycle.
    pipe_req_address   = 32'h1008;
    pipe_req_size      = BYTE;
    pipe_req_type      = STORE;
    pipe_word_to_store = 32'h77;
    pipe_req_valid     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (pipe_fetched_word_valid !== 1'b1) begin
        miscompares++; $display("FAIL store_held%0d: got valid %b want 1", k, pipe_fetched_word_valid);
      end
      @(negedge clk);
    end
    pipe_req_valid = 1'b0;
    ref_mem[32'h1008] = 32'h1234_5677;
    do_req(32'h1008, WORD, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h1234_5677) begin
      miscompares++; $display("FAIL store_repeat: got %h want 12345677", rd);
    end
    vectors++;
    if (ld_log.size() != 0 || st_addr.size() != 0) begin
      miscompares++; $display("FAIL store_traffic: got %0d/%0d want 0/0", ld_log.size(), st_addr.size());
    end
  endtask

  task automatic test_writeback();
    logic [31:0] rd;
    int cyc;
    logic [31:0] wb_exp [4];
    wb_exp = '{32'hBEEF_AAAA, 32'h1122_5C44, 32'h1234_5677, 32'h0102_0304};
    clear_logs();
    do_req(32'h1100, WORD, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'h0BAD_F00D || cyc != 9) begin
      miscompares++; $display("FAIL wb_load: got %h in %0d cycles want 0badf00d in 9", rd, cyc);
    end
    vectors++;
    if (st_addr.size() != 4 || ld_log.size() != 4) begin
      miscompares++;
      $display("FAIL wb_traffic: got %0d stores %0d loads want 4 4", st_addr.size(), ld_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (st_addr[i] !== 32'h1000 + 32'(4 * i) || st_data[i] !== wb_exp[i]) begin
          miscompares++;
          $display("FAIL wb_word%0d: got %h@%h want %h@%h", i, st_data[i], st_addr[i], wb_exp[i],
                   32'h1000 + 4 * i);
        end
        vectors++;
        if (ld_log[i] !== 32'h1100 + 32'(4 * i)) begin
          miscompares++; $display("FAIL wb_fill%0d: got %h want %h", i, ld_log[i], 32'h1100 + 4 * i);
        end
      end
    end
    clear_logs();
    do_req(32'h1003, BYTE, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== 32'hBE || cyc != 5 || st_addr.size() != 0) begin
      miscompares++;
      $display("FAIL wb_reload: got %h in %0d cycles %0d stores want 000000be in 5 0 stores", rd,
               cyc, st_addr.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd;
    int cyc;
    int k = 0;
    pipe_req_address = 32'h2004;
    pipe_req_size    = WORD;
    pipe_req_type    = LOAD;
    pipe_req_valid   = 1'b1;
    #1;
    while (!(l2_req_valid === 1'b1 && l2_req_address === 32'h2008) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    vectors++;
    if (k >= 20) begin
      miscompares++; $display("FAIL midfill_reach: got no fill of word 2, want it within 20 cycles");
    end
    reset = 1'b1;
    pipe_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    do_req(32'h2004, WORD, LOAD, 32'h0, rd, cyc);
    vectors++;
    if (rd !== exp_load(32'h2004, WORD) || cyc != 5) begin
      miscompares++;
      $display("FAIL midfill_refetch: got %h in %0d cycles want %h in 5", rd, cyc,
               exp_load(32'h2004, WORD));
    end
    vectors++;
    if (ld_log.size() != 4 || st_addr.size() != 0) begin
      miscompares++;
      $display("FAIL midfill_traffic: got %0d loads %0d stores want 4 0", ld_log.size(), st_addr.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    memory_operation_size_e s;
    int cyc;
    int unsigned exp_misses = 0;
`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hits0, misses0;
    hits0   = hit_count;
    misses0 = miss_count;
`endif
    stall_en = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      a = 32'h4000 + ($urandom_range(0, 127) << 3) + $urandom_range(0, 7);
      s = memory_operation_size_e'($urandom_range(0, 2));
      do_req(a, s, LOAD, 32'h0, rd, cyc);
      if (cyc != 0) exp_misses++;
      vectors++;
      if (rd !== exp_load(a, s)) begin
        miscompares++;
        $display("FAIL rand_load%0d: addr %h size %0d got %h want %h", i, a, s, rd, exp_load(a, s));
      end
    end
    stall_en = 1'b0;
`ifdef DCACHE_PERF_COUNTERS_EN
    vectors++;
    if (hit_count - hits0 !== 32'd2048 || miss_count - misses0 !== exp_misses) begin
      miscompares++;
      $display("FAIL perf_counts: got hits %0d misses %0d want 2048 %0d", hit_count - hits0,
               miss_count - misses0, exp_misses);
    end
`endif
  endtask

  initial begin
    reset              = 1'b1;
    pipe_req_address   = '0;
    pipe_req_size      = WORD;
    pipe_req_type      = LOAD;
    pipe_req_valid     = 1'b0;
    pipe_word_to_store = '0;
    l2_mem[32'h1000] = 32'hAAAA_AAAA;  ref_mem[32'h1000] = 32'hAAAA_AAAA;
    l2_mem[32'h1004] = 32'h1122_3344;  ref_mem[32'h1004] = 32'h1122_3344;
    l2_mem[32'h1008] = 32'h1234_5678;  ref_mem[32'h1008] = 32'h1234_5678;
    l2_mem[32'h100C] = 32'hCAFE_F00D;  ref_mem[32'h100C] = 32'hCAFE_F00D;
    l2_mem[32'h1100] = 32'h0BAD_F00D;  ref_mem[32'h1100] = 32'h0BAD_F00D;
    @(negedge clk);
    test_reset();
    test_cold_load();
    test_hit();
    test_store();
    test_writeback();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
